// File: rtl/registrador_pisos_pkg.sv
// Shared sizing and index-map helpers for the floor-request register.
// Bit layout, floor f 0-based:
//   hall up   = 2f          (f = 0 .. N-2)
//   hall down = 2f-1        (f = 1 .. N-1)
//   cab       = 2(N-1) + f  (f = 0 .. N-1)
package registrador_pkg;

    // Total request bits: (N-1) hall up + (N-1) hall down + N cab.
    function automatic int calc_n_botones(input int n_pisos);
        return 3 * n_pisos - 2;
    endfunction

    // Width of a floor number, never below one bit.
    function automatic int calc_pw(input int n_pisos);
        return (n_pisos <= 2) ? 1 : $clog2(n_pisos);
    endfunction

    // Width of a population count able to hold every bit set at once.
    function automatic int calc_cw(input int n_pisos);
        return $clog2(3 * n_pisos - 1);
    endfunction

    // Hall-up bit of floor f (valid for f < N-1).
    function automatic int idx_sube(input int f);
        return 2 * f;
    endfunction

    // Hall-down bit of floor f (valid for f > 0).
    function automatic int idx_baja(input int f);
        return 2 * f - 1;
    endfunction

    // Cab bit of floor f.
    function automatic int idx_cabina(input int f, input int n_pisos);
        return 2 * (n_pisos - 1) + f;
    endfunction

    // Floor that a request bit belongs to.
    function automatic int piso_de(input int idx, input int n_pisos);
        int base_cab;
        base_cab = 2 * (n_pisos - 1);
        if (idx >= base_cab)
            return idx - base_cab;
        else if ((idx % 2) == 0)
            return idx / 2;
        else
            return (idx + 1) / 2;
    endfunction

endpackage

// File: rtl/registrador_pisos_detector_flancos.sv
// Rising-edge detector over a vector of button levels.
// The previous-level register clears on reset, so a level held through
// reset is reported as a fresh edge on the first cycle afterwards.
module detector_flancos #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] nivel_i,
    output logic [W-1:0] flanco_o
);

    logic [W-1:0] prev_q;
    logic [W-1:0] prev_d;

    // Next value of the level history is simply the current level.
    always_comb begin
        prev_d = nivel_i;
    end

    // Level history register, cleared on reset.
    always_ff @(posedge clk) begin
        if (reset)
            prev_q <= '0;
        else
            prev_q <= prev_d;
    end

    assign flanco_o = nivel_i & ~prev_q;

endmodule

// File: rtl/registrador_pisos.sv
// Floor-request register for the elevator controller.
// Latches button presses on their rising edge, holds each request until
// the car serves it, and summarises pending work relative to the car.
module registrador_pisos
    import registrador_pkg::*;
#(
    parameter  int N_PISOS   = 4,
    localparam int N_BOTONES = calc_n_botones(N_PISOS),
    localparam int PW        = calc_pw(N_PISOS),
    localparam int CW        = calc_cw(N_PISOS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BOTONES-1:0] botones,
    input  logic [PW-1:0]        piso_actual,
    input  logic                 atender,
    input  logic                 dir_subiendo,
    output logic [N_BOTONES-1:0] pendientes,
    output logic                 hay_arriba,
    output logic                 hay_abajo,
    output logic                 hay_aqui,
    output logic [CW-1:0]        num_pendientes
);

    logic [N_BOTONES-1:0] flanco;
    logic [N_BOTONES-1:0] pend_q;
    logic [N_BOTONES-1:0] pend_d;
    logic [N_BOTONES-1:0] borrar;
    logic [N_PISOS-1:0]   sel_piso;
    logic [31:0]          piso_ext;
    logic                 piso_valido;

    logic                 arriba_c;
    logic                 abajo_c;
    logic                 aqui_c;
    logic [CW-1:0]        cuenta_c;

    detector_flancos #(
        .W (N_BOTONES)
    ) u_flancos (
        .clk      (clk),
        .reset    (reset),
        .nivel_i  (botones),
        .flanco_o (flanco)
    );

    assign piso_ext    = 32'(piso_actual);
    assign piso_valido = (piso_ext < N_PISOS);

    // One-hot decode of the served floor; empty for an illegal floor
    // or when no service is requested, so atender is ignored there.
    always_comb begin
        sel_piso = '0;
        for (int f = 0; f < N_PISOS; f++) begin
            sel_piso[f] = atender && piso_valido && (piso_ext == f);
        end
    end

    // Bits served at the current stop: the cab bit always, plus the hall
    // bit matching the direction. End floors have one hall bit only, so it
    // is served whatever the direction.
    always_comb begin
        borrar = '0;
        for (int f = 0; f < N_PISOS; f++) begin
            if (sel_piso[f])
                borrar[idx_cabina(f, N_PISOS)] = 1'b1;
        end
        for (int f = 0; f < N_PISOS - 1; f++) begin
            if (sel_piso[f] && (dir_subiendo || f == 0))
                borrar[idx_sube(f)] = 1'b1;
        end
        for (int f = 1; f < N_PISOS; f++) begin
            if (sel_piso[f] && (!dir_subiendo || f == N_PISOS - 1))
                borrar[idx_baja(f)] = 1'b1;
        end
    end

    // New presses set bits, served bits clear; clear wins on the same bit,
    // and since the edge is consumed a held button does not re-latch.
    always_comb begin
        pend_d = (pend_q | flanco) & ~borrar;
    end

    // Pending request register; reset discards every request.
    always_ff @(posedge clk) begin
        if (reset)
            pend_q <= '0;
        else
            pend_q <= pend_d;
    end

    // Position summaries and population count from the registered vector.
    always_comb begin
        arriba_c = 1'b0;
        abajo_c  = 1'b0;
        aqui_c   = 1'b0;
        cuenta_c = '0;
        for (int i = 0; i < N_BOTONES; i++) begin
            cuenta_c = cuenta_c + CW'(pend_q[i]);
            if (pend_q[i] && piso_valido) begin
                if (piso_ext < piso_de(i, N_PISOS))
                    arriba_c = 1'b1;
                else if (piso_ext > piso_de(i, N_PISOS))
                    abajo_c = 1'b1;
                else
                    aqui_c = 1'b1;
            end
        end
    end

    assign pendientes     = pend_q;
    assign hay_arriba     = arriba_c;
    assign hay_abajo      = abajo_c;
    assign hay_aqui       = aqui_c;
    assign num_pendientes = cuenta_c;

endmodule

// File: tb/tb_registrador_pisos.sv
// Bench for registrador_pisos: a 4-floor instance checked against a
// cycle model through a scoreboard, and a 3-floor instance used for the
// illegal-floor case.
module tb_registrador_pisos;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- 4-floor instance ----------------
    logic       reset4;
    logic [9:0] bot4;
    logic [1:0] piso4;
    logic       at4;
    logic       dir4;
    logic [9:0] pend4;
    logic       arr4, abj4, aqui4;
    logic [3:0] cnt4;

    registrador_pisos #(.N_PISOS(4)) dut4 (
        .clk            (clk),
        .reset          (reset4),
        .botones        (bot4),
        .piso_actual    (piso4),
        .atender        (at4),
        .dir_subiendo   (dir4),
        .pendientes     (pend4),
        .hay_arriba     (arr4),
        .hay_abajo      (abj4),
        .hay_aqui       (aqui4),
        .num_pendientes (cnt4)
    );

    // ---------------- 3-floor instance ----------------
    logic       reset3;
    logic [6:0] bot3;
    logic [1:0] piso3;
    logic       at3;
    logic       dir3;
    logic [6:0] pend3;
    logic       arr3, abj3, aqui3;
    logic [2:0] cnt3;

    registrador_pisos #(.N_PISOS(3)) dut3 (
        .clk            (clk),
        .reset          (reset3),
        .botones        (bot3),
        .piso_actual    (piso3),
        .atender        (at3),
        .dir_subiendo   (dir3),
        .pendientes     (pend3),
        .hay_arriba     (arr3),
        .hay_abajo      (abj3),
        .hay_aqui       (aqui3),
        .num_pendientes (cnt3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (4 floors) ----------------
    // Floor of each request bit: up1 down2 up2 down3 up3 down4 cab1..cab4.
    localparam int FLOOR4 [10] = '{0, 1, 1, 2, 2, 3, 0, 1, 2, 3};

    typedef struct packed {
        logic [9:0] pend;
        logic       arr;
        logic       abj;
        logic       aqui;
        logic [3:0] num;
    } exp_t;

    exp_t       sb[$];
    logic [9:0] m_pend = '0;
    logic [9:0] m_prev = '0;

    function automatic logic [9:0] served_mask(input int f, input logic d);
        logic [9:0] m;
        m = '0;
        m[6 + f] = 1'b1;                       // cab of floor f
        case (f)
            0:       m[0] = 1'b1;              // only up1 exists
            3:       m[5] = 1'b1;              // only down4 exists
            1:       if (d) m[2] = 1'b1; else m[1] = 1'b1;
            default: if (d) m[4] = 1'b1; else m[3] = 1'b1;
        endcase
        return m;
    endfunction

    task automatic model_push(input logic r, input logic [9:0] b, input logic [1:0] p,
                              input logic a, input logic d);
        exp_t e;
        logic [9:0] press;
        logic [9:0] clr;
        if (r) begin
            m_pend = '0;
            m_prev = '0;
        end else begin
            press  = b & ~m_prev;
            clr    = a ? served_mask(int'(p), d) : 10'h000;
            m_pend = (m_pend | press) & ~clr;
            m_prev = b;
        end
        e.pend = m_pend;
        e.arr  = 1'b0;
        e.abj  = 1'b0;
        e.aqui = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (m_pend[i]) begin
                if (FLOOR4[i] > int'(p))      e.arr  = 1'b1;
                else if (FLOOR4[i] < int'(p)) e.abj  = 1'b1;
                else                          e.aqui = 1'b1;
            end
        end
        e.num = 4'($countones(m_pend));
        sb.push_back(e);
    endtask

    // Drive one cycle of stimulus, then compare the DUT against the oldest
    // expectation just after the edge.
    task automatic step(input logic r, input logic [9:0] b, input logic [1:0] p,
                        input logic a, input logic d, input string tag);
        exp_t e;
        reset4 = r; bot4 = b; piso4 = p; at4 = a; dir4 = d;
        model_push(r, b, p, a, d);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_pend"}, 32'(pend4), 32'(e.pend));
            chk({tag, "_arr"},  32'(arr4),  32'(e.arr));
            chk({tag, "_abj"},  32'(abj4),  32'(e.abj));
            chk({tag, "_aqui"}, 32'(aqui4), 32'(e.aqui));
            chk({tag, "_num"},  32'(cnt4),  32'(e.num));
        end
    endtask

    initial begin
        reset4 = 1'b1; bot4 = '0; piso4 = '0; at4 = 1'b0; dir4 = 1'b0;
        reset3 = 1'b1; bot3 = '0; piso3 = '0; at3 = 1'b0; dir3 = 1'b0;

        // Buttons held through reset are reported once reset releases.
        step(1, 10'h3FF, 0, 0, 0, "rst_held");
        chk("rst_pend_zero", 32'(pend4), 32'h0);
        step(0, 10'h3FF, 0, 0, 0, "post_rst1");
        chk("post_rst1_all", 32'(pend4), 32'h3FF);
        chk("post_rst1_cnt", 32'(cnt4), 32'd10);
        step(0, 10'h3FF, 0, 0, 0, "post_rst2");

        // Cab4 press seen from floor 1, then held for five cycles.
        step(1, 10'h000, 1, 0, 0, "clr");
        step(0, 10'h200, 1, 0, 0, "cab4");
        chk("cab4_pend", 32'(pend4), 32'h200);
        chk("cab4_arr", 32'(arr4), 32'd1);
        for (int k = 0; k < 5; k++) step(0, 10'h200, 1, 0, 0, "cab4_hold");

        // up2 + down3 + cab2 served at floor 1 going up, then floor 2 going down.
        step(1, 10'h000, 1, 0, 0, "clr2");
        step(0, 10'h08C, 1, 0, 0, "set3");
        step(0, 10'h000, 1, 1, 1, "srv_up1");
        chk("srv_up1_pend", 32'(pend4), 32'h008);
        step(0, 10'h000, 2, 1, 0, "srv_dn2");
        chk("srv_dn2_pend", 32'(pend4), 32'h000);

        // Press and service of up1 in the same cycle: clear wins, no re-latch.
        step(0, 10'h001, 0, 1, 0, "race");
        chk("race_bit0", 32'(pend4[0]), 32'd0);
        step(0, 10'h001, 0, 0, 0, "race_hold");
        step(0, 10'h000, 0, 0, 0, "race_rel");
        step(0, 10'h001, 0, 0, 0, "race_repress");
        chk("repress_bit0", 32'(pend4[0]), 32'd1);

        // Reset mid-operation discards requests.
        step(0, 10'h155, 2, 0, 0, "set155");
        step(0, 10'h000, 2, 0, 0, "rel155");
        chk("set155_pend", 32'(pend4), 32'h155);
        step(1, 10'h000, 2, 0, 0, "rst_mid");
        chk("rst_mid_pend", 32'(pend4), 32'h0);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            logic [9:0] b;
            b = bot4;
            if ($urandom_range(0, 2) == 0) b[$urandom_range(0, 9)] = ~b[$urandom_range(0, 9)];
            if ($urandom_range(0, 3) == 0) b = b ^ 10'($urandom_range(0, 1023));
            step(($urandom_range(0, 59) == 0), b, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), "rand");
        end

        // 3-floor instance: illegal floor 3 ignores atender and blanks summaries.
        reset3 = 1'b1; bot3 = 7'h7F;
        @(posedge clk); #1;
        chk("n3_rst_pend", 32'(pend3), 32'h0);
        reset3 = 1'b0;
        @(posedge clk); #1;
        chk("n3_all_pend", 32'(pend3), 32'h7F);
        chk("n3_all_cnt", 32'(cnt3), 32'd7);
        bot3 = 7'h00; piso3 = 2'd3; at3 = 1'b1; dir3 = 1'b1;
        @(posedge clk); #1;
        chk("n3_ill_pend", 32'(pend3), 32'h7F);
        chk("n3_ill_arr", 32'(arr3), 32'd0);
        chk("n3_ill_abj", 32'(abj3), 32'd0);
        chk("n3_ill_aqui", 32'(aqui3), 32'd0);
        chk("n3_ill_cnt", 32'(cnt3), 32'd7);
        dir3 = 1'b0;
        @(posedge clk); #1;
        chk("n3_ill_dn_pend", 32'(pend3), 32'h7F);
        at3 = 1'b0; piso3 = 2'd1;
        @(posedge clk); #1;
        chk("n3_f1_arr", 32'(arr3), 32'd1);
        chk("n3_f1_abj", 32'(abj3), 32'd1);
        chk("n3_f1_aqui", 32'(aqui3), 32'd1);
        at3 = 1'b1; dir3 = 1'b1;
        @(posedge clk); #1;
        chk("n3_srv_f1_up", 32'(pend3), 32'h5B);
        chk("n3_srv_f1_cnt", 32'(cnt3), 32'd5);
        at3 = 1'b0;

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
